// File: rtl/uart_pkg.sv
// Shared UART constants and TX state encoding, common to the TX and RX FIFO paths.
package uart_pkg;

    localparam int unsigned FIFO_DEPTH   = 16;
    localparam int unsigned PTR_W        = 4;
    localparam int unsigned LVL_W        = 5;
    localparam int unsigned LOW_WATER_M0 = 8;
    localparam int unsigned LOW_WATER_M1 = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular TX byte FIFO with single-byte push, flattened bulk load and drop reporting.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    input  logic               load_all,
    input  logic [LVL_W-1:0]   load_count,
    input  logic [DEPTH*8-1:0] data_in_flat,
    input  logic               pop,
    output logic [7:0]         rd_data,
    output logic [LVL_W-1:0]   level,
    output logic               fifo_full,
    output logic               fifo_empty,
    output logic               err_drop
);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] level_q, level_d, load_cnt;
    logic             load_req, load_ok, push_ok, pop_ok, err_d, err_q;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_W'(DEPTH));
    assign load_cnt   = (load_count > LVL_W'(DEPTH)) ? LVL_W'(DEPTH) : load_count;

    // A bulk load request always wins over a single write, even when it is rejected.
    assign load_req = load_all && (load_count != '0);
    assign load_ok  = load_req && fifo_empty && !pop;
    assign push_ok  = !load_req && wr_en && !fifo_full;
    assign pop_ok   = pop && !fifo_empty;
    assign err_d    = (load_req && !load_ok) || (!load_req && wr_en && fifo_full);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        if (load_ok) begin
            rd_ptr_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + PTR_W'(load_cnt);
            level_d  = load_cnt;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop_ok)      level_d = level_q + LVL_W'(1);
            else if (!push_ok && pop_ok) level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (load_ok) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (k < 32'(load_cnt)) mem_q[wr_ptr_q + PTR_W'(k)] <= data_in_flat[8*k +: 8];
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            err_q    <= err_d;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign level    = level_q;
    assign err_drop = err_q;

endmodule

// File: rtl/uart_tx_burst.sv
// Buffered UART transmitter: TX FIFO feeding an 8N1 LSB-first serializer paced by baud_tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_burst
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH     = FIFO_DEPTH,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               baud_tick,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    input  logic               load_all,
    input  logic [LVL_W-1:0]   load_count,
    input  logic [DEPTH*8-1:0] data_in_flat,
    input  logic               mode,
    output logic               tx,
    output logic               tx_busy,
    output logic               flag_space,
    output logic               fifo_full,
    output logic               fifo_empty,
    output logic [LVL_W-1:0]   level,
    output logic               err_drop
);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d, rd_data;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d, stop_last;
    logic       tx_q, tx_d, busy_q, pop;
`ifdef UART_TX_PARITY_EN
    logic       parity_q;
`endif

    uart_tx_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .load_all    (load_all),
        .load_count  (load_count),
        .data_in_flat(data_in_flat),
        .pop         (pop),
        .rd_data     (rd_data),
        .level       (level),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .err_drop    (err_drop)
    );

    assign stop_last = (STOP_BITS < 2) || stop_cnt_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        if (baud_tick) begin
            case (state_q)
                StIdle: pop = !fifo_empty;
                StStart: begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = StData;
                end
                StData: begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = StParity;
`else
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = StStop;
`endif
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                StParity: begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = StStop;
                end
                StStop: begin
                    if (stop_last) begin
                        pop     = !fifo_empty;
                        state_d = StIdle;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = StIdle;
                end
            endcase
            // Popping from idle or the last stop tick both launch a start bit immediately.
            if (pop) begin
                shift_d = rd_data;
                tx_d    = 1'b0;
                state_d = StStart;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= (state_d != StIdle);
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   parity_q <= 1'b0;
        else if (pop) parity_q <= ^rd_data;
    end
`endif

    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign flag_space = mode ? (level <= LVL_W'(LOW_WATER_M1)) : (level <= LVL_W'(LOW_WATER_M0));

endmodule

// File: tb/tb_uart_tx_burst.sv
// Scoreboard bench for uart_tx_burst: queue model of accepted bytes, line-decoding monitor.
module tb_uart_tx_burst;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned TICK_DIV = 16;
`ifdef UART_TX_PARITY_EN
    localparam int LAST = 10;
`else
    localparam int LAST = 9;
`endif

    logic         clk, reset, baud_tick, wr_en, load_all, mode;
    logic [7:0]   wr_data;
    logic [4:0]   load_count;
    logic [127:0] data_in_flat;
    logic         tx, tx_busy, flag_space, fifo_full, fifo_empty, err_drop;
    logic [4:0]   level;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_q[$];
    logic       err_pend;
    bit         tick_en;
    int         mon_pos;
    int         mon_frames;
    int         mon_idle_starts;
    int         mon_busy_ticks;
    logic [7:0] mon_byte, mon_exp;
    logic       mon_prev_tx;

    uart_tx_burst dut (
        .clk         (clk),
        .reset       (reset),
        .baud_tick   (baud_tick),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .load_all    (load_all),
        .load_count  (load_count),
        .data_in_flat(data_in_flat),
        .mode        (mode),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .flag_space  (flag_space),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .level       (level),
        .err_drop    (err_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int div;
        div = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_en && div == int'(TICK_DIV) - 1) begin
                baud_tick = 1'b1;
                div = 0;
            end else begin
                baud_tick = 1'b0;
                if (tick_en) div++;
            end
        end
    end

    // Monitor: decodes the line one bit period per tick and scores each finished frame.
    initial begin
        mon_pos = -1;
        mon_frames = 0;
        mon_idle_starts = 0;
        mon_busy_ticks = 0;
        mon_prev_tx = 1'b1;
        mon_byte = '0;
        mon_exp = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                mon_pos = -1;
                mon_prev_tx = 1'b1;
            end else begin
                if (baud_tick) begin
                    if (mon_pos == -1 || mon_pos == LAST) begin
                        if (tx == 1'b0) begin
                            if (mon_pos == -1) mon_idle_starts++;
                            if (model_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_frame: start bit seen, none expected at %0t",
                                         $time);
                                mon_exp = 'x;
                            end else begin
                                mon_exp = model_q.pop_front();
                            end
                            mon_pos = 0;
                            mon_byte = '0;
                        end else begin
                            mon_pos = -1;
                        end
                    end else begin
                        mon_pos++;
                        if (mon_pos >= 1 && mon_pos <= 8) mon_byte[mon_pos-1] = tx;
`ifdef UART_TX_PARITY_EN
                        if (mon_pos == 9) check("parity_bit", tx, ^mon_exp);
`endif
                        if (mon_pos == LAST) begin
                            check("stop_bit", tx, 1);
                            check("frame_byte", mon_byte, mon_exp);
                            mon_frames++;
                        end
                    end
                    if (mon_pos != -1) mon_busy_ticks++;
                end else begin
                    check("tx_hold", tx, mon_prev_tx);
                end
                check("tx_busy", tx_busy, mon_pos != -1);
                mon_prev_tx = tx;
            end
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        check("level", level, model_q.size());
        check("fifo_empty", fifo_empty, model_q.size() == 0);
        check("fifo_full", fifo_full, model_q.size() == DEPTH);
        check("flag_space", flag_space, model_q.size() <= (mode ? 2 : 8));
        check("err_drop", err_drop, err_pend);
        err_pend = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        if (model_q.size() == DEPTH) err_pend = 1'b1;
        else model_q.push_back(b);
        next_cycle();
        wr_en = 1'b0;
    endtask

    task automatic bulk(input int cnt, input logic [127:0] flat, input bit with_wr);
        int n;
        n = (cnt > 16) ? 16 : cnt;
        load_all = 1'b1;
        load_count = cnt[4:0];
        data_in_flat = flat;
        wr_en = with_wr;
        wr_data = 8'hEE;
        if (model_q.size() == 0) begin
            for (int k = 0; k < n; k++) model_q.push_back(flat[8*k +: 8]);
        end else begin
            err_pend = 1'b1;
        end
        next_cycle();
        load_all = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((model_q.size() != 0 || mon_pos != -1) && n < budget) begin
            next_cycle();
            n++;
        end
        check("drain_done", (model_q.size() == 0 && mon_pos == -1), 1);
    endtask

    initial begin
        logic [127:0] flat;
        int r, n, f0, s0, b0;
        reset = 1'b0;
        wr_en = 1'b0;
        wr_data = '0;
        load_all = 1'b0;
        load_count = '0;
        data_in_flat = '0;
        mode = 1'b0;
        tick_en = 1'b0;
        err_pend = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_busy", tx_busy, 0);
        next_cycle();
        reset = 1'b1;
        tick_en = 1'b1;
        next_cycle();

        // Single frame 0xA5: ten bit periods busy.
        b0 = mon_busy_ticks;
        push(8'hA5);
        drain(1000);
        check("a5_busy_ticks", mon_busy_ticks - b0, LAST + 1);
        check("a5_idle_tx", tx, 1);

        // Full bulk load, then a rejected push, then one continuous burst.
        tick_en = 1'b0;
        repeat (2) next_cycle();
        for (int k = 0; k < 16; k++) flat[8*k +: 8] = 8'(k);
        bulk(16, flat, 1'b0);
        push(8'hFF);
        repeat (2) next_cycle();
        f0 = mon_frames;
        s0 = mon_idle_starts;
        tick_en = 1'b1;
        drain(4000);
        check("burst_frames", mon_frames - f0, 16);
        check("burst_idle_starts", mon_idle_starts - s0, 1);

        // Load rejected while holding three bytes; contents must survive.
        tick_en = 1'b0;
        repeat (2) next_cycle();
        push(8'h31);
        push(8'h32);
        push(8'h33);
        bulk(4, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        repeat (2) next_cycle();
        tick_en = 1'b1;
        drain(2000);

        // Load and write together on an empty FIFO: only the bulk bytes land.
        tick_en = 1'b0;
        repeat (2) next_cycle();
        flat = '0;
        flat[7:0] = 8'h41;
        flat[15:8] = 8'h42;
        bulk(2, flat, 1'b1);
        tick_en = 1'b1;
        drain(2000);

        // Parity patterns (plain frames when parity is not built in).
        b0 = mon_busy_ticks;
        push(8'h07);
        push(8'h03);
        drain(2000);
        check("parity_pair_busy_ticks", mon_busy_ticks - b0, 2 * (LAST + 1));

        // Asynchronous reset during data bit 4 of 0x3C with five bytes queued behind it.
        push(8'h3C);
        for (int k = 0; k < 5; k++) push(8'(8'h11 + k));
        n = 0;
        while (!(mon_pos == 5 && mon_exp == 8'h3C) && n < 2000) begin
            next_cycle();
            n++;
        end
        check("reached_data_bit4", (mon_pos == 5 && mon_exp == 8'h3C), 1);
        check("level_before_reset", level, 5);
        #3;
        reset = 1'b0;
        model_q.delete();
        err_pend = 1'b0;
        #1;
        check("async_reset_tx", tx, 1);
        check("async_reset_busy", tx_busy, 0);
        check("async_reset_level", level, 0);
        repeat (3) next_cycle();
        reset = 1'b1;
        repeat (100) next_cycle();
        check("post_reset_tx", tx, 1);

        // Randomized traffic: bursts of pushes, occasional bulk loads, mode flips.
        for (int c = 0; c < 6000; c++) begin
            r = int'($urandom_range(0, 99));
            if (c % 500 == 0) mode = 1'($urandom_range(0, 1));
            if (r < (((c / 1000) % 2 == 1) ? 5 : 1)) begin
                push(8'($urandom_range(0, 255)));
            end else if (r < 7 && r >= 6) begin
                bulk(int'($urandom_range(1, 20)), {$urandom, $urandom, $urandom, $urandom},
                     1'($urandom_range(0, 1)));
            end else begin
                next_cycle();
            end
        end
        drain(6000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
